dbus_sram_responder: RTL

Memory-side responder for the core's data bus. Accepts `dbus_req_t` requests from the memory stage, executes byte-strobed writes and aligned 64-bit reads against an internal word array, and answers with `dbus_resp_t` after a fixed, parameterised latency. Reads always return the full aligned doubleword; lane selection and sign/zero extension stay on the requester side. Used as the data memory model in simulation and as a tightly coupled data SRAM in synthesis.

---
 rtl/dbus_pkg.sv | 25 ++
 rtl/dbus_sram_responder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dbus_pkg.sv
// Data-bus request/response types shared by the memory stage and its responders.
package dbus_pkg;

  typedef logic [2:0] msize_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder.sv
// Fixed-latency data-bus SRAM responder: byte-strobed writes and aligned 64-bit reads.
// Writes commit at the accept edge; the response is delivered LATENCY cycles later.
module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
  localparam logic [63:0] END_ADDR = BASE_ADDR + SPAN;
  localparam logic [3:0]  LAT_M1   = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [63:0] mem_q [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] cap_data_q, cap_data_d;
  logic        cap_err_q, cap_err_d;
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;
  logic        data_ok_q, data_ok_d;

  logic             accept_s, range_err_s, align_err_s, req_err_s, wr_en_s;
  logic [63:0]      offset_s, old_word_s, merged_s, resp_word_s;
  logic [IDX_W-1:0] idx_s;

  // Decode the presented request: word index, error class and merged write data
  always_comb begin
    offset_s    = dreq.addr - BASE_ADDR;
    idx_s       = IDX_W'(offset_s >> 3);
    range_err_s = (dreq.addr < BASE_ADDR) || (dreq.addr >= END_ADDR);
    case (dreq.size)
      MSIZE2:  align_err_s = dreq.addr[0];
      MSIZE4:  align_err_s = (dreq.addr[1:0] != 2'b00);
      MSIZE8:  align_err_s = (dreq.addr[2:0] != 3'b000);
      default: align_err_s = 1'b0;
    endcase
    req_err_s  = range_err_s | align_err_s;
    old_word_s = mem_q[idx_s];
    merged_s   = old_word_s;
    // A zero strobe leaves the old word intact, so reads share the merge path
    for (int i = 0; i < 8; i++) begin
      if (dreq.strobe[i]) begin
        merged_s[8*i +: 8] = dreq.data[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = old_word_s[8*i +: 8];
      end
    end
    accept_s    = (state_q == S_IDLE) && dreq.valid;
    wr_en_s     = accept_s && reset_n && (dreq.strobe != 8'h00) && !req_err_s;
    resp_word_s = req_err_s ? 64'h0 : merged_s;
  end

  // Transaction sequencing and response staging
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_data_d = cap_data_q;
    cap_err_d  = cap_err_q;
    data_d     = data_q;
    err_d      = err_q;
    data_ok_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cap_data_d = resp_word_s;
          cap_err_d  = req_err_s;
          cnt_d      = LAT_M1;
          if (LATENCY <= 1) begin
            state_d   = S_RESP;
            data_d    = resp_word_s;
            err_d     = req_err_s;
            data_ok_d = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        // Leaving at count 1 puts data_ok exactly LATENCY cycles after the accept
        if (cnt_q <= 4'd1) begin
          state_d   = S_RESP;
          data_d    = cap_data_q;
          err_d     = cap_err_q;
          data_ok_d = 1'b1;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      cap_data_q <= 64'h0;
      cap_err_q  <= 1'b0;
      data_q     <= 64'h0;
      err_q      <= 1'b0;
      data_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_data_q <= cap_data_d;
      cap_err_q  <= cap_err_d;
      data_q     <= data_d;
      err_q      <= err_d;
      data_ok_q  <= data_ok_d;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_s] <= merged_s;
    end
  end

  // addr_ok is a combinational handshake; everything else comes from flops
  always_comb begin
    dresp.addr_ok = (state_q == S_IDLE) && dreq.valid;
    dresp.data_ok = data_ok_q;
    dresp.data    = data_q;
    err           = err_q;
  end

endmodule
